rf_sequencer: RTL and testbench



---
 rtl/rf_seq_pkg.sv | 24 ++
 rtl/rf_seq_alu.sv | 47 ++++
 rtl/rf_sequencer.sv | 132 +++++++++++++
 tb/tb_rf_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// Shared encodings for the register-file sequencer: FSM state codes and
// command opcodes.
package rf_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ_A = 3'd1,
        S_READ_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_MOVI = 2'b00,
        OP_MOV  = 2'b01,
        OP_ADD  = 2'b10,
        OP_AND  = 2'b11
    } op_e;

    function automatic logic op_needs_b(input op_e op);
        return (op == OP_ADD) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational result/flag generator for the sequencer's EXEC step.
// V is meaningful only for ADD; every other op reports 0.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  op_e                  i_op,
    input  logic signed [W-1:0]  i_a,
    input  logic signed [W-1:0]  i_b,
    input  logic        [W-1:0]  i_imm,
    output logic        [W-1:0]  o_result,
    output logic                 o_z,
    output logic                 o_n,
    output logic                 o_v
);

    logic signed [W-1:0] w_sum;

    // Two same-signed operands producing a differently-signed sum overflowed.
    function automatic logic add_ovf(input logic signed [W-1:0] a,
                                     input logic signed [W-1:0] b,
                                     input logic signed [W-1:0] s);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    assign w_sum = i_a + i_b;

    always_comb begin
        o_result = i_imm;
        o_v      = 1'b0;
        case (i_op)
            OP_MOVI: o_result = i_imm;
            OP_MOV:  o_result = i_a;
            OP_ADD: begin
                o_result = w_sum;
                o_v      = add_ovf(i_a, i_b, w_sum);
            end
            OP_AND:  o_result = i_a & i_b;
            default: o_result = i_imm;
        endcase
    end

    assign o_z = (o_result == '0);
    assign o_n = o_result[W-1];

endmodule

// File: rtl/rf_sequencer.sv
// Command-driven initiator for an 8x16 register file: reads up to two
// sources, computes one result, writes it back and pulses done.
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [W-1:0]  cmd_imm,
    output logic [AW-1:0] rf_readnum,
    input  logic [W-1:0]  rf_data_out,
    output logic [AW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [W-1:0]  rf_data_in,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_v
);

    state_e        r_state;
    state_e        w_state_nxt;
    op_e           r_op;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_rs1;
    logic [AW-1:0] r_rs2;
    logic [W-1:0]  r_imm;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_result;
    logic          r_z;
    logic          r_n;
    logic          r_v;
    logic          r_done;
    logic          w_accept;
    logic [W-1:0]  w_alu_result;
    logic          w_alu_z;
    logic          w_alu_n;
    logic          w_alu_v;

    assign w_accept = cmd_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid)
                    w_state_nxt = (op_e'(cmd_op) == OP_MOVI) ? S_EXEC : S_READ_A;
            end
            S_READ_A: w_state_nxt = op_needs_b(r_op) ? S_READ_B : S_EXEC;
            S_READ_B: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = S_WRITE;
            S_WRITE:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch, operand capture and EXEC result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_MOVI;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_WRITE);
            if (w_accept) begin
                r_op  <= op_e'(cmd_op);
                r_rd  <= cmd_rd;
                r_rs1 <= cmd_rs1;
                r_rs2 <= cmd_rs2;
                r_imm <= cmd_imm;
            end
            if (r_state == S_READ_A) r_a <= rf_data_out;
            if (r_state == S_READ_B) r_b <= rf_data_out;
            if (r_state == S_EXEC) begin
                r_result <= w_alu_result;
                r_z      <= w_alu_z;
                r_n      <= w_alu_n;
                r_v      <= w_alu_v;
            end
        end
    end

    rf_seq_alu #(
        .W (W)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_imm    (r_imm),
        .o_result (w_alu_result),
        .o_z      (w_alu_z),
        .o_n      (w_alu_n),
        .o_v      (w_alu_v)
    );

    // Write enable is decoded straight from state so an async reset kills it at once.
    assign cmd_ready   = (r_state == S_IDLE);
    assign rf_readnum  = (r_state == S_READ_B) ? r_rs2 : r_rs1;
    assign rf_write    = (r_state == S_WRITE);
    assign rf_writenum = r_rd;
    assign rf_data_in  = r_result;
    assign done        = r_done;
    assign result      = r_result;
    assign flag_z      = r_z;
    assign flag_n      = r_n;
    assign flag_v      = r_v;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer paired with an 8x16 register file; expected values
// come from an arithmetic reference model of the register contents.
module tb_rf_sequencer;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
    } cmd_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic [15:0] cmd_imm;
    logic [2:0]  rf_readnum;
    logic [15:0] rf_data_out;
    logic [2:0]  rf_writenum;
    logic        rf_write;
    logic [15:0] rf_data_in;
    logic        done;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;

    logic [15:0] rf_mem   [8];
    logic [15:0] ref_regs [8];
    int          n_cmp;
    int          n_err;

    rf_sequencer #(
        .W  (16),
        .AW (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs1     (cmd_rs1),
        .cmd_rs2     (cmd_rs2),
        .cmd_imm     (cmd_imm),
        .rf_readnum  (rf_readnum),
        .rf_data_out (rf_data_out),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_data_in  (rf_data_in),
        .done        (done),
        .result      (result),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_v      (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: one write port, combinational read.
    always @(posedge clk) begin
        if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
    end
    assign rf_data_out = rf_mem[rf_readnum];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_res(input cmd_t c);
        int a;
        int b;
        a = int'(ref_regs[c.rs1]);
        b = int'(ref_regs[c.rs2]);
        case (c.op)
            2'd0:    return c.imm;
            2'd1:    return 16'(a);
            2'd2:    return 16'((a + b) % 65536);
            default: return 16'(a & b);
        endcase
    endfunction

    function automatic logic ref_v(input cmd_t c);
        int sa;
        int sb;
        int s;
        if (c.op != 2'd2) return 1'b0;
        sa = int'(ref_regs[c.rs1]);
        sb = int'(ref_regs[c.rs2]);
        if (sa >= 32768) sa = sa - 65536;
        if (sb >= 32768) sb = sb - 65536;
        s = sa + sb;
        return (s > 32767) || (s < -32768);
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.op  = 2'($urandom_range(0, 3));
        c.rd  = 3'($urandom_range(0, 7));
        c.rs1 = 3'($urandom_range(0, 7));
        c.rs2 = 3'($urandom_range(0, 7));
        c.imm = 16'($urandom);
        return c;
    endfunction

    function automatic cmd_t mk(input int op, input int rd, input int rs1, input int rs2, input int imm);
        cmd_t c;
        c.op  = 2'(op);
        c.rd  = 3'(rd);
        c.rs1 = 3'(rs1);
        c.rs2 = 3'(rs2);
        c.imm = 16'(imm);
        return c;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    // After the handshake the inputs switch to `nxt` (valid = hold) for the whole operation.
    task automatic do_cmd(input cmd_t c, input logic hold, input cmd_t nxt);
        logic [15:0] exp;
        logic        ev;
        int          exp_lat;
        int          lat;
        logic        got;
        cmd_op    = c.op;
        cmd_rd    = c.rd;
        cmd_rs1   = c.rs1;
        cmd_rs2   = c.rs2;
        cmd_imm   = c.imm;
        cmd_valid = 1'b1;
        chk("ready_idle", cmd_ready, 1);
        exp     = ref_res(c);
        ev      = ref_v(c);
        exp_lat = (c.op == 2'd0) ? 3 : (c.op == 2'd1) ? 4 : 5;
        @(posedge clk);
        #1;
        cmd_valid = hold;
        cmd_op    = nxt.op;
        cmd_rd    = nxt.rd;
        cmd_rs1   = nxt.rs1;
        cmd_rs2   = nxt.rs2;
        cmd_imm   = nxt.imm;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (done) begin
                got = 1'b1;
            end else begin
                chk("ready_busy", cmd_ready, 0);
                chk("rf_write", rf_write, (lat == exp_lat - 1));
                if (lat == 1 && c.op != 2'd0) chk("readnum_a", rf_readnum, c.rs1);
                if (lat == 2 && c.op >= 2'd2) chk("readnum_b", rf_readnum, c.rs2);
                if (lat == exp_lat - 1) begin
                    chk("writenum", rf_writenum, c.rd);
                    chk("data_in", rf_data_in, exp);
                end
            end
        end
        chk("latency", lat, exp_lat);
        chk("result", result, exp);
        chk("flag_z", flag_z, (exp == 16'h0000));
        chk("flag_n", flag_n, (exp >= 16'h8000));
        chk("flag_v", flag_v, ev);
        chk("rf_dest", rf_mem[c.rd], exp);
        ref_regs[c.rd] = exp;
    endtask

    initial begin
        cmd_t idle_c;
        cmd_t cur;
        cmd_t nxt;
        logic hold;
        n_cmp = 0;
        n_err = 0;
        idle_c = mk(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_rd = 3'd0;
        cmd_rs1 = 3'd0;
        cmd_rs2 = 3'd0;
        cmd_imm = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_write", rf_write, 0);
        chk("rst_readnum", rf_readnum, 0);
        chk("rst_writenum", rf_writenum, 0);
        chk("rst_data_in", rf_data_in, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_z, flag_n, flag_v}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_cmd(mk(0, 3, 0, 0, 16'h1234), 1'b0, idle_c);
        for (int r = 0; r < 8; r++) begin
            if (r != 3) do_cmd(mk(0, r, 0, 0, int'($urandom_range(0, 65535))), 1'b0, idle_c);
        end

        do_cmd(mk(0, 1, 0, 0, 16'h7FFF), 1'b0, idle_c);
        do_cmd(mk(0, 2, 0, 0, 16'h0001), 1'b0, idle_c);
        do_cmd(mk(2, 4, 1, 2, 0), 1'b0, rnd_cmd());
        chk("ovf_r4", rf_mem[4], 16'h8000);
        chk("ovf_nv", {flag_n, flag_v}, 2'b11);
        do_cmd(mk(0, 1, 0, 0, 16'hFFFF), 1'b0, idle_c);
        do_cmd(mk(2, 5, 1, 2, 0), 1'b0, rnd_cmd());
        chk("wrap_zv", {flag_z, flag_v}, 2'b10);
        do_cmd(mk(0, 1, 0, 0, 16'h0003), 1'b0, idle_c);
        do_cmd(mk(2, 1, 1, 1, 0), 1'b0, rnd_cmd());
        chk("self_add", rf_mem[1], 16'h0006);
        do_cmd(mk(0, 5, 0, 0, 16'hF0F0), 1'b0, idle_c);
        do_cmd(mk(0, 6, 0, 0, 16'h0F0F), 1'b0, idle_c);
        do_cmd(mk(3, 2, 5, 6, 0), 1'b0, rnd_cmd());
        chk("and_z", flag_z, 1);

        // Three queued commands with cmd_valid held high throughout.
        do_cmd(mk(0, 3, 0, 0, 16'h5A5A), 1'b1, mk(2, 4, 3, 3, 16'hFFFF));
        do_cmd(mk(2, 4, 3, 3, 16'hFFFF), 1'b1, mk(3, 5, 4, 3, 0));
        do_cmd(mk(3, 5, 4, 3, 0), 1'b0, rnd_cmd());
        chk("queue_r5", rf_mem[5], 16'h5A5A & 16'hB4B4);

        // Reset asserted while an ADD to R7 sits in READ_B.
        do_cmd(mk(0, 7, 0, 0, 16'hAAAA), 1'b0, idle_c);
        cmd_op = 2'd2;
        cmd_rd = 3'd7;
        cmd_rs1 = 3'd1;
        cmd_rs2 = 3'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rb_busy", cmd_ready, 0);
        chk("rb_readnum", rf_readnum, 2);
        rst_n = 1'b0;
        #1;
        chk("arst_write", rf_write, 0);
        chk("arst_ready", cmd_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_write", rf_write, 0);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_write", rf_write, 0);
            chk("post_rst_done", done, 0);
            chk("post_rst_ready", cmd_ready, 1);
        end
        chk("r7_kept", rf_mem[7], 16'hAAAA);

        do_cmd(mk(1, 0, 7, 0, 0), 1'b0, rnd_cmd());
        chk("mov_r0", rf_mem[0], 16'hAAAA);

        cur = rnd_cmd();
        for (int i = 0; i < 40; i++) begin
            nxt  = rnd_cmd();
            hold = 1'($urandom_range(0, 1));
            do_cmd(cur, hold, nxt);
            if (!hold) begin
                @(negedge clk);
                chk("done_pulse", done, 0);
                chk("idle_ready", cmd_ready, 1);
            end
            cur = nxt;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
